pipeline_stall_controller: RTL and testbench

- Central sequencer for the 5-stage RV32I pipeline.
- Merges three stall sources into per-stage load and flush controls:
  - data-hazard stall from the ID hazard detector;
  - taken-branch redirect resolved in EX;
  - multi-cycle data-memory access in MEM, using a req/ready handshake.
- Sits beside the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC, and drives every load/flush enable.

---
 rtl/pipeline_stall_controller.sv | 171 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer: merges memory stall, branch redirect and data hazard into stage enables.
// Latency: outputs are combinational (Mealy) from registered state and current inputs; state updates next edge.
// Backpressure: a pending data-memory access freezes all stages until dmem_ready or MEM_TIMEOUT wait cycles.
//
// Ports:
//   clock, reset                 - rising-edge clock, asynchronous active-high reset
//   data_hazard                  - ID-stage RAW hazard; stalls PC and IF/ID, injects a bubble into ID/EX
//   branch_taken_ex              - taken branch/jump in EX; flushes IF/ID and ID/EX, then BRANCH_PENALTY-1 IF/ID flushes
//   mem_access, dmem_ready       - MEM-stage load/store and its completion strobe
//   dmem_req                     - data memory request, held until ready or timeout
//   *_load, *_flush              - PC and pipeline register enables / NOP-insert controls
//   mem_error                    - sticky memory timeout flag (cleared only by reset)
//   stall_count                  - cycles with pc_load low; only built when PIPE_PERF_CNT_EN is defined, else 0
module pipeline_stall_controller #(
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_hazard,
  input  logic        branch_taken_ex,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        id_ex_load,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_error,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FLUSH_EXTRA = 3'(BRANCH_PENALTY - 1);
  localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       mem_error_q, mem_error_d;

  // Ungated controls; the outputs are forced low while reset is held.
  logic req_c, pc_c, ifid_c, idex_c, exmem_c, memwb_c, ifid_fl_c, idex_fl_c;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_error_d = mem_error_q;
    req_c       = 1'b0;
    pc_c        = 1'b1;
    ifid_c      = 1'b1;
    idex_c      = 1'b1;
    exmem_c     = 1'b1;
    memwb_c     = 1'b1;
    ifid_fl_c   = 1'b0;
    idex_fl_c   = 1'b0;

    case (state_q)
      RUN, FLUSH: begin
        req_c = mem_access;
        if (mem_access && !dmem_ready) begin
          // Memory stall wins over everything; any remaining flush cycles are
          // dropped because fetch was already redirected.
          {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b0;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (state_q == FLUSH) begin
          // Branch in EX here is a flushed bubble, so it is ignored.
          ifid_fl_c   = 1'b1;
          flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
          if (flush_cnt_q <= 3'd1) begin
            state_d = RUN;
          end
        end else if (branch_taken_ex) begin
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          if (MULTI_FLUSH) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_EXTRA;
          end
        end else if (data_hazard) begin
          pc_c      = 1'b0;
          ifid_c    = 1'b0;
          idex_fl_c = 1'b1;
        end
      end

      MEM_WAIT: begin
        req_c = 1'b1;
        {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b0;
        if (dmem_ready) begin
          {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b11111;
          state_d = RUN;
          // A branch that waited behind the access is redirected now.
          if (branch_taken_ex) begin
            ifid_fl_c = 1'b1;
            idex_fl_c = 1'b1;
            if (MULTI_FLUSH) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_EXTRA;
            end
          end
        end else if (wait_cnt_q >= TIMEOUT_CNT) begin
          // Abort: let the instruction retire with undefined data.
          {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b11111;
          req_c       = 1'b0;
          mem_error_d = 1'b1;
          state_d     = RUN;
        end else begin
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 3'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign dmem_req    = req_c     & ~reset;
  assign pc_load     = pc_c      & ~reset;
  assign if_id_load  = ifid_c    & ~reset;
  assign id_ex_load  = idex_c    & ~reset;
  assign ex_mem_load = exmem_c   & ~reset;
  assign mem_wb_load = memwb_c   & ~reset;
  assign if_id_flush = ifid_fl_c & ~reset;
  assign id_ex_flush = idex_fl_c & ~reset;
  assign mem_error   = mem_error_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_load) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (BRANCH_PENALTY=2, MEM_TIMEOUT=16).
// Output vector order: {dmem_req, pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_flush}.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_pipeline_stall_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        data_hazard = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic        mem_access = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        dmem_req, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush, mem_error;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  localparam logic [7:0] IDLE   = 8'h7C;  // all loads, no flush
  localparam logic [7:0] HAZ    = 8'h1D;  // pc/if_id held, bubble into ID/EX
  localparam logic [7:0] BR     = 8'h7F;  // all loads, both flushes
  localparam logic [7:0] FL     = 8'h7E;  // all loads, IF/ID flush only
  localparam logic [7:0] MSTALL = 8'h80;  // req, everything frozen
  localparam logic [7:0] MDONE  = 8'hFC;  // req, all loads
  localparam logic [7:0] MBR    = 8'hFF;  // req, all loads, both flushes
  localparam logic [7:0] MHAZ   = 8'h9D;  // req plus hazard pattern
  localparam logic [7:0] NONE   = 8'h00;

  pipeline_stall_controller #(.BRANCH_PENALTY(2), .MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .data_hazard(data_hazard), .branch_taken_ex(branch_taken_ex),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_load(pc_load), .if_id_load(if_id_load),
    .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  wire [7:0] outs = {dmem_req, pc_load, if_id_load, id_ex_load, ex_mem_load,
                     mem_wb_load, if_id_flush, id_ex_flush};

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp_v);
    checks++;
    assert (mem_error === exp_v) else begin
      errors++;
      $error("FAIL %s mem_error observed=%b expected=%b", tag, mem_error, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [31:0] exp_v;
`ifdef PIPE_PERF_CNT_EN
    exp_v = 32'(exp_stall);
`else
    exp_v = 32'd0;
`endif
    checks++;
    assert (stall_count === exp_v) else begin
      errors++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic ma, input logic rdy, input logic br, input logic hz,
                     input logic [7:0] exp_v, input string tag);
    mem_access      = ma;
    dmem_ready      = rdy;
    branch_taken_ex = br;
    data_hazard     = hz;
    #4;
    chk8(tag, outs, exp_v);
    if (!exp_v[6]) exp_stall++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state.
    #3;
    chk8("reset_outs", outs, NONE);
    chk_err("reset_err", 1'b0);
    chk_cnt("reset_cnt");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Data hazard for one cycle, then release.
    cyc(0, 0, 0, 0, IDLE, "idle0");
    cyc(0, 0, 0, 1, HAZ,  "hazard");
    cyc(0, 0, 0, 0, IDLE, "after_hazard");

    // Taken branch, penalty 2.
    cyc(0, 0, 1, 0, BR,   "branch_c0");
    cyc(0, 0, 0, 0, FL,   "branch_c1");
    cyc(0, 0, 0, 0, IDLE, "branch_c2");

    // Memory access waiting 3 cycles.
    cyc(1, 0, 0, 0, MSTALL, "mem_w1");
    cyc(1, 0, 0, 0, MSTALL, "mem_w2");
    cyc(1, 0, 0, 0, MSTALL, "mem_w3");
    cyc(1, 1, 0, 0, MDONE,  "mem_done");
    cyc(0, 0, 0, 0, IDLE,   "after_mem");
    chk_cnt("cnt_after_mem");

    // All three sources at once: memory wins, branch honoured on ready.
    cyc(1, 0, 1, 1, MSTALL, "prio_run");
    cyc(1, 0, 1, 1, MSTALL, "prio_wait");
    cyc(1, 1, 1, 1, MBR,    "prio_ready_branch");
    cyc(0, 0, 0, 0, FL,     "prio_flush");
    cyc(0, 0, 0, 0, IDLE,   "prio_idle");

    // Memory stall during FLUSH abandons the remaining flush cycles.
    cyc(1, 0, 1, 0, MSTALL, "run_mem_before_branch");
    cyc(1, 1, 0, 0, MDONE,  "run_mem_ready");
    cyc(0, 0, 1, 0, BR,     "abandon_branch");
    cyc(1, 0, 0, 0, MSTALL, "flush_to_memwait");
    cyc(1, 1, 0, 0, MDONE,  "flush_mem_done");
    cyc(0, 0, 0, 0, IDLE,   "flush_abandoned");

    // Branch in FLUSH is ignored.
    cyc(0, 0, 1, 0, BR,   "br2_c0");
    cyc(0, 0, 1, 0, FL,   "br2_ignored");
    cyc(0, 0, 0, 0, IDLE, "br2_done");

    // Single-cycle access with a hazard: request plus hazard pattern.
    cyc(1, 1, 0, 1, MHAZ, "mem_ready_hazard");
    cyc(0, 0, 0, 0, IDLE, "idle_pre_timeout");

    // Timeout: RUN stall cycle, then 15 plain wait cycles, abort on the 16th.
    cyc(1, 0, 0, 0, MSTALL, "to_enter");
    for (int i = 1; i < 16; i++) cyc(1, 0, 0, 0, MSTALL, "to_wait");
    chk_err("to_not_yet", 1'b0);
    cyc(1, 0, 0, 0, IDLE, "to_abort");
    chk_err("to_set", 1'b1);
    cyc(0, 0, 0, 0, IDLE, "to_run");
    cyc(0, 0, 0, 0, IDLE, "to_run2");
    chk_err("to_sticky", 1'b1);
    chk_cnt("cnt_after_timeout");

    // Reset asserted mid-MEM_WAIT.
    cyc(1, 0, 0, 0, MSTALL, "rst_enter");
    #2;
    chk8("rst_pre", outs, MSTALL);
    #1;
    reset = 1'b1;
    #1;
    chk8("rst_async", outs, NONE);
    chk_err("rst_async_err", 1'b0);
    @(posedge clock);
    #1;
    chk8("rst_held", outs, NONE);
    mem_access = 1'b0;
    exp_stall  = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc(0, 0, 0, 0, IDLE, "rst_release");
    chk_err("rst_release_err", 1'b0);
    chk_cnt("rst_release_cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
